des_iterative_engine: RTL and testbench
=======================================

DES_ITERATIVE_ENGINE -- requirements
Module: des_iterative_engine

Interface
REQ-001 SHALL have parameter NUM_ROUNDS, default 16, number of Feistel rounds; legal values are 1..16.
REQ-002 SHALL have parameter UNROLL, default 1, rounds evaluated per clock; legal values are 1, 2, 4, 8 or 16, dividing NUM_ROUNDS; illegal values SHALL fail elaboration.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 in_valid  input  1  a request is present on the input port.
REQ-007 in_ready  output  1  the engine can accept a request.
REQ-008 in_decrypt  input  1  0 = encrypt, 1 = decrypt; sampled on accept.
REQ-009 in_key  input  64  DES key, bit 63 = DES bit 1; parity bits (DES bits 8,16,...,64) are ignored.
REQ-010 in_data  input  64  plaintext or ciphertext block, bit 63 = DES bit 1.
REQ-011 out_valid  output  1  out_data holds a result.
REQ-012 out_ready  input  1  the consumer takes the result.
REQ-013 out_data  output  64  result block.
REQ-014 busy  output  1  the engine is in state RUN or DONE.

Function
REQ-015 SHALL implement FSM states IDLE, RUN and DONE.
REQ-016 in_ready SHALL be high only in IDLE with reset low (combinational).
REQ-017 Accept = in_valid & in_ready at a rising edge.
  - On accept: register IP(in_data) into L/R, PC1(in_key) into C/D, and in_decrypt.
  - Round counter = 0; next state RUN.
REQ-018 In RUN, each edge SHALL apply UNROLL rounds in sequence and add UNROLL to the counter.
  - Each round SHALL use the existing Expansion, S_Boxes and Permutation blocks, with subkey PC2(C,D).
REQ-019 Encrypt subkey schedule:
  - Before round r (1-based), C and D SHALL each rotate left by SHIFT[r].
  - SHIFT = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
REQ-020 Decrypt subkey schedule:
  - On accept, C and D SHALL be pre-rotated left by the sum of SHIFT[1..NUM_ROUNDS] mod 28, an elaboration-time constant.
  - Round j SHALL use the current C,D, then rotate right by SHIFT[NUM_ROUNDS-j+1].
  - Subkeys are therefore applied in reverse order.
REQ-021 After the round in which the counter reaches NUM_ROUNDS, the engine SHALL:
  - load out_data = FP({R,L}), i.e. with the final swap;
  - set out_valid = 1;
  - enter DONE.
  - Latency: out_valid is high in the cycle following the edge that is NUM_ROUNDS/UNROLL edges after the accept edge.
REQ-022 In DONE, out_data and out_valid SHALL hold stable while out_ready is low.
REQ-023 When out_valid & out_ready are both high at an edge, out_valid SHALL clear and the state SHALL go to IDLE.
  - The next accept is possible one edge later, at the earliest.
  - Throughput is one block per NUM_ROUNDS/UNROLL + 2 cycles.
REQ-024 The engine SHALL ignore in_valid, in_data, in_key and in_decrypt outside IDLE.
REQ-025 out_ready SHALL be ignored while out_valid is low.
REQ-026 The round counter SHALL be ceil(log2(NUM_ROUNDS+1)) bits wide and SHALL NOT wrap in legal operation.
REQ-027 Parity bits of in_key SHALL NOT affect any output.

Reset
REQ-028 With reset high at an edge, the engine SHALL set:
  - state = IDLE;
  - out_valid = 0, out_data = 0, busy = 0;
  - L, R, C, D and the counter = 0.
REQ-029 reset SHALL take priority over every other input, including a simultaneous accept.
REQ-030 reset asserted in RUN or DONE SHALL abort the operation, and no out_valid pulse SHALL follow.
REQ-031 in_ready SHALL be high in the first cycle after reset deasserts.

Verification
REQ-032 Encrypt, defaults:
  - Stimulus: key 133457799BBCDFF1, data 0123456789ABCDEF.
  - Required: out_data 85E813540F0AB405, with out_valid 16 cycles after accept.
REQ-033 Decrypt, defaults:
  - Stimulus: key 133457799BBCDFF1, data 85E813540F0AB405.
  - Required: out_data 0123456789ABCDEF.
  - Also: key 0E329232EA6D0D73, data 0000000000000000 -> out_data 8787878787878787.
REQ-034 Parity:
  - Stimulus: key 1235567 89ABDDEF0 written as 123556789ABDDEF0 (all parity bits flipped), data 0123456789ABCDEF.
  - Required: out_data 85E813540F0AB405.
REQ-035 Backpressure:
  - Stimulus: hold out_ready low 5 cycles after out_valid; hold in_valid high throughout.
  - Required: out_data stable; in_ready = 0 and busy = 1 during the hold; exactly one accept per completed result.
REQ-036 Reset mid-RUN:
  - Stimulus: reset for 1 cycle at round counter 7.
  - Required: busy = 0 and in_ready = 1 on the next cycle; no out_valid.
  - A fresh REQ-032 request then yields the correct ciphertext.
REQ-037 Parameter sweep:
  - UNROLL = 4: REQ-032 vectors give the same result, out_valid 4 cycles after accept.
  - NUM_ROUNDS = 8: encrypt followed by decrypt with the same key returns the original 0123456789ABCDEF.

Source files
------------

// File: rtl/des_iterative_engine_if.sv
// Request/result handshake bundle for des_iterative_engine.
//   in_valid/in_ready   : request handshake (master -> engine)
//   in_decrypt          : 0 = encrypt, 1 = decrypt
//   in_key/in_data      : 64-bit key and block, bit 63 = DES bit 1
//   out_valid/out_ready : result handshake (engine -> master)
//   out_data            : 64-bit result block
interface des_iterative_engine_if;
  localparam int unsigned BLK_W = 64;

  logic             in_valid;
  logic             in_ready;
  logic             in_decrypt;
  logic [BLK_W-1:0] in_key;
  logic [BLK_W-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [BLK_W-1:0] out_data;

  modport master (
    output in_valid, in_decrypt, in_key, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_decrypt, in_key, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/des_iterative_engine.sv
// Iterative DES encrypt/decrypt engine, UNROLL Feistel rounds per clock.
//   clk   : rising-edge clock
//   reset : synchronous active-high reset
//   busy  : engine is in RUN or DONE
//   bus   : request/result handshake (slave side)
module des_iterative_engine #(
  parameter int unsigned NUM_ROUNDS = 16,
  parameter int unsigned UNROLL     = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   busy,
  des_iterative_engine_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(NUM_ROUNDS + 1);

  if (NUM_ROUNDS < 1 || NUM_ROUNDS > 16 ||
      (UNROLL != 1 && UNROLL != 2 && UNROLL != 4 && UNROLL != 8 && UNROLL != 16) ||
      (NUM_ROUNDS % UNROLL) != 0) begin : g_bad_params
    $error("des_iterative_engine: illegal NUM_ROUNDS/UNROLL combination");
  end

  // Bit r-1 set means round r rotates by 2, otherwise by 1.
  localparam logic [15:0] SHIFT2 = 16'h7EFC;

  localparam int unsigned IP_T [64] = '{
    58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
    62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
    57,49,41,33,25,17,9,1,  59,51,43,35,27,19,11,3,
    61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
  localparam int unsigned PC1_T [56] = '{
    57,49,41,33,25,17,9,  1,58,50,42,34,26,18, 10,2,59,51,43,35,27, 19,11,3,60,52,44,36,
    63,55,47,39,31,23,15, 7,62,54,46,38,30,22, 14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
  localparam int unsigned PC2_T [48] = '{
    14,17,11,24,1,5,   3,28,15,6,21,10,  23,19,12,4,26,8,   16,7,27,20,13,2,
    41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};
  localparam int unsigned E_T [48] = '{
    32,1,2,3,4,5,     4,5,6,7,8,9,      8,9,10,11,12,13,  12,13,14,15,16,17,
    16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};
  localparam int unsigned P_T [32] = '{
    16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10,
    2,8,24,14,32,27,3,9,    19,13,30,6,22,11,4,25};
  // Entry n = row*16 + col lives at bits [255-4n -: 4].
  localparam logic [255:0] SBOX [8] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

  // Decrypt starts from the key state the last encrypt round would use.
  function automatic int unsigned f_pre_rot();
    int unsigned s;
    s = 0;
    for (int unsigned r = 0; r < NUM_ROUNDS; r++) s = s + 1 + 32'(SHIFT2[4'(r)]);
    return s % 28;
  endfunction
  localparam int unsigned PRE_ROT = f_pre_rot();

  function automatic logic [27:0] f_rotl(input logic [27:0] x, input int unsigned n);
    return (x << n) | (x >> (28 - n));
  endfunction

  function automatic logic [63:0] f_ip(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 64; i++) y[6'(63-i)] = x[6'(64-IP_T[6'(i)])];
    return y;
  endfunction

  // Inverse of IP.
  function automatic logic [63:0] f_fp(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 64; i++) y[6'(64-IP_T[6'(i)])] = x[6'(63-i)];
    return y;
  endfunction

  function automatic logic [55:0] f_pc1(input logic [63:0] x);
    logic [55:0] y;
    for (int i = 0; i < 56; i++) y[6'(55-i)] = x[6'(64-PC1_T[6'(i)])];
    return y;
  endfunction

  function automatic logic [47:0] f_pc2(input logic [55:0] x);
    logic [47:0] y;
    for (int i = 0; i < 48; i++) y[6'(47-i)] = x[6'(56-PC2_T[6'(i)])];
    return y;
  endfunction

  // Expansion, S-boxes and P permutation.
  function automatic logic [31:0] f_feistel(input logic [31:0] r, input logic [47:0] k);
    logic [47:0] e;
    logic [5:0]  six;
    logic [5:0]  idx;
    logic [31:0] s;
    logic [31:0] p;
    for (int i = 0; i < 48; i++) e[6'(47-i)] = r[5'(32-E_T[6'(i)])];
    e = e ^ k;
    for (int b = 0; b < 8; b++) begin
      six = e[6'(47-6*b) -: 6];
      idx = {six[5], six[0], six[4:1]};
      s[5'(31-4*b) -: 4] = SBOX[3'(b)][8'(255 - 4*32'(idx)) -: 4];
    end
    for (int i = 0; i < 32; i++) p[5'(31-i)] = s[5'(32-P_T[5'(i)])];
    return p;
  endfunction

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [31:0]      r_l, r_r;
  logic [27:0]      r_c, r_d;
  logic [CNT_W-1:0] r_cnt;
  logic             r_dec;
  logic [63:0]      r_out_data;
  logic             r_out_valid;

  logic             w_in_ready;
  logic             w_busy;
  logic             w_accept;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_last;
  logic [31:0]      w_l_nxt, w_r_nxt;
  logic [27:0]      w_c_nxt, w_d_nxt;
  logic [63:0]      w_ip;
  logic [55:0]      w_pc1;

  assign w_accept  = bus.in_valid & w_in_ready;
  assign w_cnt_nxt = r_cnt + CNT_W'(UNROLL);
  assign w_last    = (w_cnt_nxt == CNT_W'(NUM_ROUNDS));
  assign w_ip      = f_ip(bus.in_data);
  assign w_pc1     = f_pc1(bus.in_key);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept)      w_state_nxt = S_RUN;
      S_RUN:   if (w_last)        w_state_nxt = S_DONE;
      S_DONE:  if (bus.out_ready) w_state_nxt = S_IDLE;
      default:                    w_state_nxt = S_IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    w_in_ready = 1'b0;
    w_busy     = 1'b0;
    case (r_state)
      S_IDLE:  w_in_ready = ~reset;
      S_RUN:   w_busy     = 1'b1;
      S_DONE:  w_busy     = 1'b1;
      default: w_busy     = 1'b0;
    endcase
  end

  // UNROLL chained rounds; decrypt uses the key state before rotating right.
  always_comb begin : p_rounds
    logic [31:0] v_l, v_r, v_t;
    logic [27:0] v_c, v_d;
    logic [47:0] v_k;
    logic [3:0]  v_sidx;
    v_l = r_l;
    v_r = r_r;
    v_c = r_c;
    v_d = r_d;
    v_t = '0;
    v_k = '0;
    v_sidx = '0;
    for (int unsigned u = 0; u < UNROLL; u++) begin
      if (!r_dec) begin
        v_sidx = 4'(32'(r_cnt) + u);
        v_c = SHIFT2[v_sidx] ? {v_c[25:0], v_c[27:26]} : {v_c[26:0], v_c[27]};
        v_d = SHIFT2[v_sidx] ? {v_d[25:0], v_d[27:26]} : {v_d[26:0], v_d[27]};
        v_k = f_pc2({v_c, v_d});
      end else begin
        v_sidx = 4'(NUM_ROUNDS - 1 - (32'(r_cnt) + u));
        v_k = f_pc2({v_c, v_d});
        v_c = SHIFT2[v_sidx] ? {v_c[1:0], v_c[27:2]} : {v_c[0], v_c[27:1]};
        v_d = SHIFT2[v_sidx] ? {v_d[1:0], v_d[27:2]} : {v_d[0], v_d[27:1]};
      end
      v_t = v_l ^ f_feistel(v_r, v_k);
      v_l = v_r;
      v_r = v_t;
    end
    w_l_nxt = v_l;
    w_r_nxt = v_r;
    w_c_nxt = v_c;
    w_d_nxt = v_d;
  end

  // Datapath and result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_l         <= '0;
      r_r         <= '0;
      r_c         <= '0;
      r_d         <= '0;
      r_cnt       <= '0;
      r_dec       <= 1'b0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_l   <= w_ip[63:32];
          r_r   <= w_ip[31:0];
          r_c   <= bus.in_decrypt ? f_rotl(w_pc1[55:28], PRE_ROT) : w_pc1[55:28];
          r_d   <= bus.in_decrypt ? f_rotl(w_pc1[27:0],  PRE_ROT) : w_pc1[27:0];
          r_dec <= bus.in_decrypt;
          r_cnt <= '0;
        end
        S_RUN: begin
          r_l   <= w_l_nxt;
          r_r   <= w_r_nxt;
          r_c   <= w_c_nxt;
          r_d   <= w_d_nxt;
          r_cnt <= w_cnt_nxt;
          if (w_last) begin
            r_out_data  <= f_fp({w_r_nxt, w_l_nxt});
            r_out_valid <= 1'b1;
          end
        end
        S_DONE: if (bus.out_ready) r_out_valid <= 1'b0;
        default: r_out_valid <= 1'b0;
      endcase
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign busy          = w_busy;

endmodule

// File: tb/tb_des_iterative_engine.sv
// Directed bench for des_iterative_engine: three instances cover the
// default configuration, UNROLL = 4 and NUM_ROUNDS = 8.
module tb_des_iterative_engine;

  localparam logic [63:0] K1 = 64'h133457799BBCDFF1;
  localparam logic [63:0] KP = 64'h123556789ABDDEF0;
  localparam logic [63:0] K2 = 64'h0E329232EA6D0D73;
  localparam logic [63:0] P1 = 64'h0123456789ABCDEF;
  localparam logic [63:0] C1 = 64'h85E813540F0AB405;
  localparam logic [63:0] C2 = 64'h8787878787878787;

  logic clk;
  logic reset;
  logic busy0, busy1, busy2;
  int   n_vec  = 0;
  int   n_fail = 0;
  int   n_acc0 = 0;

  des_iterative_engine_if b0 ();
  des_iterative_engine_if b1 ();
  des_iterative_engine_if b2 ();

  des_iterative_engine #(.NUM_ROUNDS(16), .UNROLL(1)) u_dut0 (
    .clk(clk), .reset(reset), .busy(busy0), .bus(b0));
  des_iterative_engine #(.NUM_ROUNDS(16), .UNROLL(4)) u_dut1 (
    .clk(clk), .reset(reset), .busy(busy1), .bus(b1));
  des_iterative_engine #(.NUM_ROUNDS(8), .UNROLL(1)) u_dut2 (
    .clk(clk), .reset(reset), .busy(busy2), .bus(b2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (b0.in_valid && b0.in_ready) n_acc0 <= n_acc0 + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input int w, input logic v, input logic dec,
                        input logic [63:0] key, input logic [63:0] data);
    case (w)
      0:       begin b0.in_valid = v; b0.in_decrypt = dec; b0.in_key = key; b0.in_data = data; end
      1:       begin b1.in_valid = v; b1.in_decrypt = dec; b1.in_key = key; b1.in_data = data; end
      default: begin b2.in_valid = v; b2.in_decrypt = dec; b2.in_key = key; b2.in_data = data; end
    endcase
  endtask

  task automatic set_ordy(input int w, input logic r);
    case (w)
      0:       b0.out_ready = r;
      1:       b1.out_ready = r;
      default: b2.out_ready = r;
    endcase
  endtask

  function automatic logic get_ov(input int w);
    case (w)
      0:       return b0.out_valid;
      1:       return b1.out_valid;
      default: return b2.out_valid;
    endcase
  endfunction

  function automatic logic [63:0] get_od(input int w);
    case (w)
      0:       return b0.out_data;
      1:       return b1.out_data;
      default: return b2.out_data;
    endcase
  endfunction

  function automatic logic get_ir(input int w);
    case (w)
      0:       return b0.in_ready;
      1:       return b1.in_ready;
      default: return b2.in_ready;
    endcase
  endfunction

  function automatic logic get_busy(input int w);
    case (w)
      0:       return busy0;
      1:       return busy1;
      default: return busy2;
    endcase
  endfunction

  // One request with out_ready held high; returns the result and the
  // number of cycles from the accept edge until out_valid is seen.
  task automatic xact(input int w, input logic dec, input logic [63:0] key,
                      input logic [63:0] data, output logic [63:0] res, output int cyc);
    @(negedge clk);
    set_in(w, 1'b1, dec, key, data);
    set_ordy(w, 1'b1);
    chk("in_ready_idle", 64'(get_ir(w)), 64'd1);
    @(posedge clk);
    @(negedge clk);
    set_in(w, 1'b0, ~dec, 64'hDEADBEEFCAFEF00D, 64'hFFFF0000FFFF0000);
    cyc = 0;
    while (!get_ov(w) && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    res = get_od(w);
    @(posedge clk);
    @(negedge clk);
    chk("out_valid_clears", 64'(get_ov(w)), 64'd0);
    chk("in_ready_after_result", 64'(get_ir(w)), 64'd1);
  endtask

  initial begin : main
    logic [63:0] res;
    logic [63:0] ct8;
    int          cyc;
    int          acc_base;
    logic        saw_ov;

    reset = 1'b1;
    set_in(0, 1'b0, 1'b0, '0, '0); set_ordy(0, 1'b0);
    set_in(1, 1'b0, 1'b0, '0, '0); set_ordy(1, 1'b0);
    set_in(2, 1'b0, 1'b0, '0, '0); set_ordy(2, 1'b0);
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_out_valid", 64'(get_ov(0)), 64'd0);
    chk("rst_out_data",  get_od(0), 64'd0);
    chk("rst_busy",      64'(get_busy(0)), 64'd0);
    chk("rst_in_ready",  64'(get_ir(0)), 64'd0);
    chk("rst_u4_out_valid", 64'(get_ov(1)), 64'd0);
    reset = 1'b0;
    #1;
    chk("post_rst_in_ready", 64'(get_ir(0)), 64'd1);

    // Default encrypt / decrypt / parity
    xact(0, 1'b0, K1, P1, res, cyc);
    chk("enc_data", res, C1);
    chk("enc_latency", 64'(cyc), 64'd16);
    xact(0, 1'b1, K1, C1, res, cyc);
    chk("dec_data", res, P1);
    chk("dec_latency", 64'(cyc), 64'd16);
    xact(0, 1'b1, K2, 64'h0, res, cyc);
    chk("dec_zero_data", res, C2);
    xact(0, 1'b0, KP, P1, res, cyc);
    chk("parity_data", res, C1);

    // Backpressure with in_valid held high throughout
    @(negedge clk);
    set_in(0, 1'b1, 1'b0, K1, P1);
    set_ordy(0, 1'b0);
    acc_base = n_acc0;
    @(posedge clk);
    cyc = 0;
    @(negedge clk);
    while (!get_ov(0) && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk("bp_latency", 64'(cyc), 64'd16);
    for (int i = 0; i < 6; i++) begin
      chk("bp_hold_data",     get_od(0), C1);
      chk("bp_hold_valid",    64'(get_ov(0)), 64'd1);
      chk("bp_hold_in_ready", 64'(get_ir(0)), 64'd0);
      chk("bp_hold_busy",     64'(get_busy(0)), 64'd1);
      if (i < 5) @(negedge clk);
    end
    chk("bp_accepts_first", 64'(n_acc0 - acc_base), 64'd1);
    set_ordy(0, 1'b1);
    @(posedge clk);
    @(negedge clk);
    chk("bp_valid_clears", 64'(get_ov(0)), 64'd0);
    chk("bp_in_ready_idle", 64'(get_ir(0)), 64'd1);
    set_ordy(0, 1'b0);
    @(posedge clk);
    cyc = 0;
    @(negedge clk);
    while (!get_ov(0) && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk("bp_second_data", get_od(0), C1);
    chk("bp_second_latency", 64'(cyc), 64'd16);
    set_ordy(0, 1'b1);
    @(posedge clk);
    @(negedge clk);
    set_in(0, 1'b0, 1'b0, '0, '0);
    @(posedge clk);
    @(negedge clk);
    chk("bp_accepts_total", 64'(n_acc0 - acc_base), 64'd2);
    chk("bp_idle_busy", 64'(get_busy(0)), 64'd0);

    // Reset while the round counter is 7
    set_in(0, 1'b1, 1'b0, K1, P1);
    set_ordy(0, 1'b1);
    @(posedge clk);
    @(negedge clk);
    set_in(0, 1'b0, 1'b0, '0, '0);
    repeat (7) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("abort_busy",     64'(get_busy(0)), 64'd0);
    chk("abort_in_ready", 64'(get_ir(0)), 64'd1);
    chk("abort_out_data", get_od(0), 64'd0);
    saw_ov = 1'b0;
    repeat (25) begin
      @(negedge clk);
      if (get_ov(0)) saw_ov = 1'b1;
    end
    chk("abort_no_out_valid", 64'(saw_ov), 64'd0);
    xact(0, 1'b0, K1, P1, res, cyc);
    chk("abort_fresh_enc", res, C1);

    // UNROLL = 4
    xact(1, 1'b0, K1, P1, res, cyc);
    chk("u4_enc_data", res, C1);
    chk("u4_latency", 64'(cyc), 64'd4);
    xact(1, 1'b1, K1, C1, res, cyc);
    chk("u4_dec_data", res, P1);

    // NUM_ROUNDS = 8 round trip
    xact(2, 1'b0, K1, P1, ct8, cyc);
    chk("r8_enc_latency", 64'(cyc), 64'd8);
    xact(2, 1'b1, K1, ct8, res, cyc);
    chk("r8_roundtrip", res, P1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
